ntt_stage_sequencer: RTL and testbench
======================================

# ntt_stage_sequencer

- Initiator-side controller for the per-stage cycle counters in the NTT datapath (N=1024, 64 lanes).
- Accepts one transform job over a valid/ready handshake, then runs the stages in order. For each stage it issues a one-cycle `stage_start` pulse, which drives the `in_start` input of downstream stage counters.
- It tracks the same cycle window internally, inserts drain gaps between stages, and pulses `job_done` after the final stage.
- Sits between the top-level job controller and the butterfly/memory-address stage logic.

## Interface
Parameters:
- `NUM_STAGES`, 10, number of stages per job (log2 N); ≥1
- `STAGE_CYCLES`, 32, active cycles per stage, equal to the downstream counter window; ≥2
- `GAP_CYCLES`, 2, idle drain cycles between consecutive stages; 0..15

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `job_valid`  in  1  job request
- `job_ready`  out  1  sequencer can accept a job
- `abort`  in  1  synchronous cancel of the current job
- `stage_start`  out  1  one-cycle pulse at the start of each stage
- `stage_idx`  out  max(1,$clog2(NUM_STAGES))  current stage, 0-based
- `cycle_idx`  out  $clog2(STAGE_CYCLES)  cycle within the active window
- `busy`  out  1  job in progress
- `job_done`  out  1  one-cycle pulse after the last stage completes

## Operation
States: IDLE, START, RUN, GAP, DONE.

- **IDLE**
  - `job_ready` = !`abort`.
  - `job_valid` && `job_ready` → START with stage_idx=0.
- **START**
  - `stage_start`=1 for exactly this cycle; cycle_idx←0.
  - Always → RUN.
- **RUN**
  - cycle_idx increments every cycle.
  - At cycle_idx==STAGE_CYCLES-1:
    - last stage → DONE;
    - otherwise, GAP_CYCLES>0 → GAP;
    - otherwise → START with stage_idx+1.
- **GAP**
  - Internal gap counter runs 0..GAP_CYCLES-1.
  - At the last gap cycle → START with stage_idx+1.
- **DONE**
  - `job_done`=1 for one cycle → IDLE.

General rules:
- `busy`=1 in START, RUN, GAP and DONE.
- `cycle_idx` holds 0 outside RUN.
- `stage_idx` holds its value through GAP and returns to 0 in IDLE.
- `abort`=1 in any non-IDLE state:
  - next state is IDLE; `job_done` is not pulsed;
  - `stage_idx`, `cycle_idx` and the gap counter clear to 0;
  - if `abort` is asserted in START, `stage_start` still pulses that cycle.
- `abort` and `job_valid` in the same IDLE cycle: the job is not accepted.
- `job_valid` is ignored while `job_ready`=0; no queuing.
- Reset asserted at any time: state goes to IDLE immediately and all counters go to 0.
- Reset values:
  - `job_ready`=1 once `rst` deasserts;
  - `stage_start`, `busy`, `job_done`, `stage_idx`, `cycle_idx` are all 0.
- All counters compare against parameter-derived terminals, so there is no wrap-around.

## Timing
- Job accepted on the edge ending cycle A → `stage_start` in cycle A+1.
- Window alignment: `stage_start` in cycle S → cycle_idx=0 in S+1 and STAGE_CYCLES-1 in S+STAGE_CYCLES. This matches a downstream counter reset by the same pulse.
- Next `stage_start` in cycle S+STAGE_CYCLES+1+GAP_CYCLES.
- `job_done` in cycle A+1+NUM_STAGES·(1+STAGE_CYCLES)+(NUM_STAGES-1)·GAP_CYCLES. With defaults this is A+349.
- `job_ready` returns to 1 in the cycle after `job_done`, so the earliest next accept is at cycle A+350.
- Output registering:
  - `stage_start`, `job_done`, `busy`, `stage_idx` and `cycle_idx` are decoded from registered state and counters, with no input-to-output combinational path.
  - The only exception is `job_ready`, which depends on `abort`.

## Structure
- Package `ntt_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - default constants `NTT_NUM_STAGES`=10, `NTT_STAGE_CYCLES`=32, `NTT_GAP_CYCLES`=2.
- Sub-module `seq_window_cnt`: a parameterised terminal-count counter with clear, enable and a `last` flag. It is instantiated twice, once for cycle_idx and once for the gap counter.
- The FSM and stage_idx register live in the top module.

## Test plan
- **Default job:** reset, then `job_valid` held high from cycle 0 (accepted at cycle 0).
  - Expect 10 `stage_start` pulses at cycles 1, 36, 71, …, 316.
  - Expect `job_done` at cycle 349 and `job_ready` back high at cycle 350.
- **Window alignment:** after each `stage_start` at cycle S, `cycle_idx` runs 0..31 over cycles S+1..S+32, and `stage_idx` steps 0..9.
- **GAP_CYCLES=0, NUM_STAGES=2:** pulses at cycles 1 and 34, `job_done` at cycle 67.
- **Abort in RUN:**
  - Abort at stage 3, cycle_idx=5 → next cycle IDLE, `busy`=0, idx outputs 0, and no `job_done`.
  - A new job accepted immediately afterwards starts again at stage_idx=0.
- **Simultaneous events:**
  - `abort`+`job_valid` in IDLE → no accept.
  - `job_valid` held through DONE → accepted only in the following IDLE cycle.
- **Async reset mid-GAP:** `rst` low between stages 4 and 5 → outputs go to reset values immediately and no further `stage_start` occurs.

Source files
------------

// File: rtl/ntt_seq_pkg.sv
// Shared types and default constants for the NTT stage sequencer.
package ntt_seq_pkg;

    localparam int NTT_NUM_STAGES   = 10;
    localparam int NTT_STAGE_CYCLES = 32;
    localparam int NTT_GAP_CYCLES   = 2;

    // Wide enough for the largest allowed gap length (15 cycles).
    localparam int GAP_CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_GAP,
        S_DONE
    } seq_state_t;

    // A single-stage job still needs a one-bit stage index.
    function automatic int stage_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Job handshake and stage-timing bundle between the job controller and the sequencer.
interface ntt_stage_sequencer_if
    import ntt_seq_pkg::*;
#(
    parameter int NUM_STAGES   = NTT_NUM_STAGES,
    parameter int STAGE_CYCLES = NTT_STAGE_CYCLES
);
    localparam int SW = stage_idx_width(NUM_STAGES);
    localparam int CW = $clog2(STAGE_CYCLES);

    logic          job_valid;
    logic          job_ready;
    logic          abort;
    logic          stage_start;
    logic [SW-1:0] stage_idx;
    logic [CW-1:0] cycle_idx;
    logic          busy;
    logic          job_done;

    modport master (
        output job_valid, abort,
        input  job_ready, stage_start, stage_idx, cycle_idx, busy, job_done
    );

    modport slave (
        input  job_valid, abort,
        output job_ready, stage_start, stage_idx, cycle_idx, busy, job_done
    );

endinterface

// File: rtl/seq_window_cnt.sv
// Up-counter that stops at a fixed terminal value and flags it via 'last'.
module seq_window_cnt #(
    parameter int WIDTH    = 5,
    parameter int TERMINAL = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    // Clear wins over enable; the count never steps past TERMINAL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !last) begin
            count <= count + WIDTH'(1);
        end
    end

    assign last = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Runs one NTT job as a sequence of fixed-length stages separated by drain gaps.
module ntt_stage_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int NUM_STAGES   = NTT_NUM_STAGES,
    parameter int STAGE_CYCLES = NTT_STAGE_CYCLES,
    parameter int GAP_CYCLES   = NTT_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    ntt_stage_sequencer_if.slave  bus
);

    localparam int SW       = stage_idx_width(NUM_STAGES);
    localparam int CW       = $clog2(STAGE_CYCLES);
    localparam int GAP_TERM = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [SW-1:0]        stage_q;
    logic [CW-1:0]        cyc_cnt;
    logic                 cyc_last;
    logic                 cyc_clr;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 gap_last;
    logic                 gap_clr;
    logic                 in_run;
    logic                 in_gap;
    logic                 unused_gap_bits;

    assign in_run = (state_q == S_RUN);
    assign in_gap = (state_q == S_GAP);

    // Counters return to zero as soon as their window ends so they read 0 elsewhere.
    assign cyc_clr = !in_run || bus.abort || cyc_last;
    assign gap_clr = !in_gap || bus.abort || gap_last;

    seq_window_cnt #(
        .WIDTH    (CW),
        .TERMINAL (STAGE_CYCLES - 1)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cyc_clr),
        .en    (in_run),
        .count (cyc_cnt),
        .last  (cyc_last)
    );

    seq_window_cnt #(
        .WIDTH    (GAP_CNT_W),
        .TERMINAL (GAP_TERM)
    ) u_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (gap_clr),
        .en    (in_gap),
        .count (gap_cnt),
        .last  (gap_last)
    );

    // Only the gap terminal flag steers the FSM; the raw gap count is not exported.
    assign unused_gap_bits = ^gap_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort overrides everything once a job is running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.job_valid && !bus.abort) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (cyc_last) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_GAP:   if (gap_last) state_d = S_START;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // Stage index steps on every re-entry to START and clears whenever we head to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else if (state_d == S_IDLE) begin
            stage_q <= '0;
        end else if (state_d == S_START && state_q != S_IDLE) begin
            stage_q <= stage_q + SW'(1);
        end
    end

    // Output decode from registered state; job_ready alone looks at abort.
    always_comb begin
        bus.job_ready   = (state_q == S_IDLE) && !bus.abort;
        bus.stage_start = (state_q == S_START);
        bus.busy        = (state_q != S_IDLE);
        bus.job_done    = (state_q == S_DONE);
        bus.stage_idx   = stage_q;
        bus.cycle_idx   = cyc_cnt;
    end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for two sequencer configurations driven with directed and random jobs.
module tb_ntt_stage_sequencer;

    typedef struct {
        int dut;
        int cyc;
        bit is_done;
        int stage;
    } exp_ev_t;

    // Configuration 0 uses the defaults, configuration 1 has no gaps and two stages.
    int p_n  [2] = '{10, 2};
    int p_sc [2] = '{32, 32};
    int p_g  [2] = '{2, 0};

    logic clk;
    logic rst;
    int   cyc;
    bit   mon_en;
    int   checks;
    int   errors;

    bit      active     [2];
    int      acc        [2];
    int      first_done [2];
    exp_ev_t exp_q[$];

    int base;
    int a2;
    int a3;

    ntt_stage_sequencer_if #(.NUM_STAGES(10), .STAGE_CYCLES(32)) bus_a ();
    ntt_stage_sequencer_if #(.NUM_STAGES(2),  .STAGE_CYCLES(32)) bus_b ();

    ntt_stage_sequencer #(
        .NUM_STAGES   (10),
        .STAGE_CYCLES (32),
        .GAP_CYCLES   (2)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ntt_stage_sequencer #(
        .NUM_STAGES   (2),
        .STAGE_CYCLES (32),
        .GAP_CYCLES   (0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input int d, input bit v, input bit a);
        if (d == 0) begin
            bus_a.job_valid = v;
            bus_a.abort     = a;
        end else begin
            bus_b.job_valid = v;
            bus_b.abort     = a;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush_all();
        active[0] = 1'b0;
        active[1] = 1'b0;
        exp_q.delete();
    endtask

    // Reference: a job accepted at cycle A occupies periods of (1+SC+G) cycles starting at A+1.
    task automatic checkOutput(input int d);
        int t, o, per, done_off, k, r, idx;
        int a_ss, a_jd, a_bz, a_jr, a_si, a_ci, in_v, in_ab;
        int e_bz, e_si, e_ci;
        bit found, job_ends;
        exp_ev_t ev;

        t = cyc;
        if (d == 0) begin
            a_ss = int'(bus_a.stage_start); a_jd = int'(bus_a.job_done);
            a_bz = int'(bus_a.busy);        a_jr = int'(bus_a.job_ready);
            a_si = int'(bus_a.stage_idx);   a_ci = int'(bus_a.cycle_idx);
            in_v = int'(bus_a.job_valid);   in_ab = int'(bus_a.abort);
        end else begin
            a_ss = int'(bus_b.stage_start); a_jd = int'(bus_b.job_done);
            a_bz = int'(bus_b.busy);        a_jr = int'(bus_b.job_ready);
            a_si = int'(bus_b.stage_idx);   a_ci = int'(bus_b.cycle_idx);
            in_v = int'(bus_b.job_valid);   in_ab = int'(bus_b.abort);
        end

        per      = 1 + p_sc[d] + p_g[d];
        done_off = p_n[d] * (1 + p_sc[d]) + (p_n[d] - 1) * p_g[d];
        e_bz = 0; e_si = 0; e_ci = 0; job_ends = 1'b0;
        if (active[d] && t > acc[d]) begin
            o = t - acc[d] - 1;
            e_bz = 1;
            if (o >= done_off) begin
                e_si = p_n[d] - 1;
                job_ends = 1'b1;
            end else begin
                k = o / per;
                r = o % per;
                e_si = k;
                if (r >= 1 && r <= p_sc[d]) e_ci = r - 1;
            end
        end

        checkValue($sformatf("busy[%0d]", d), a_bz, e_bz);
        checkValue($sformatf("stage_idx[%0d]", d), a_si, e_si);
        checkValue($sformatf("cycle_idx[%0d]", d), a_ci, e_ci);
        checkValue($sformatf("job_ready[%0d]", d), a_jr, (e_bz == 0 && in_ab == 0) ? 1 : 0);

        idx = 0;
        while (idx < exp_q.size()) begin
            if (exp_q[idx].dut == d && exp_q[idx].cyc < t) begin
                checks++;
                errors++;
                $display("[TB] FAIL missed_pulse[%0d]: got none expected %s at cycle %0d", d,
                         exp_q[idx].is_done ? "job_done" : "stage_start", exp_q[idx].cyc);
                exp_q.delete(idx);
            end else begin
                idx++;
            end
        end

        if (a_ss != 0 || a_jd != 0) begin
            found = 1'b0;
            idx = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (!found && exp_q[i].dut == d) begin
                    idx = i;
                    found = 1'b1;
                end
            end
            if (!found) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse[%0d]: got ss=%0d done=%0d expected no pulse at cycle %0d",
                         d, a_ss, a_jd, t);
            end else begin
                ev = exp_q[idx];
                exp_q.delete(idx);
                checkValue($sformatf("pulse_cycle[%0d]", d), t, ev.cyc);
                checkValue($sformatf("pulse_kind[%0d]", d), a_jd, int'(ev.is_done));
                checkValue($sformatf("pulse_stage[%0d]", d), a_si, ev.stage);
                if (a_jd != 0 && first_done[d] < 0) first_done[d] = t;
            end
        end

        if (job_ends) begin
            active[d] = 1'b0;
        end else if (e_bz != 0 && in_ab != 0) begin
            active[d] = 1'b0;
            idx = 0;
            while (idx < exp_q.size()) begin
                if (exp_q[idx].dut == d && exp_q[idx].cyc > t) exp_q.delete(idx);
                else idx++;
            end
        end

        if (e_bz == 0 && in_v != 0 && in_ab == 0) begin
            active[d] = 1'b1;
            acc[d]    = t;
            for (int s = 0; s < p_n[d]; s++) begin
                ev.dut = d; ev.cyc = t + 1 + s * per; ev.is_done = 1'b0; ev.stage = s;
                exp_q.push_back(ev);
            end
            ev.dut = d; ev.cyc = t + 1 + done_off; ev.is_done = 1'b1; ev.stage = p_n[d] - 1;
            exp_q.push_back(ev);
        end
    endtask

    // Monitor samples both DUTs mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput(0);
            checkOutput(1);
        end
    end

    initial begin
        cyc = 0;
        mon_en = 1'b0;
        checks = 0;
        errors = 0;
        first_done[0] = -1;
        first_done[1] = -1;
        flush_all();
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Default job on both DUTs, valid held high from the first cycle.
        base = cyc;
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b0);
        mon_en = 1'b1;
        wait_until(base + 1);
        applyStimulus(1, 1'b0, 1'b0);

        // Abort together with valid while idle must not start a job.
        wait_until(base + 100);
        applyStimulus(1, 1'b1, 1'b1);
        wait_until(base + 101);
        applyStimulus(1, 1'b0, 1'b0);

        // Valid still held through DONE: second job lands at base+350.
        wait_until(base + 351);
        applyStimulus(0, 1'b0, 1'b0);
        a2 = base + 350;

        // Abort at stage 3, cycle_idx 5, then restart right away.
        wait_until(a2 + 112);
        applyStimulus(0, 1'b0, 1'b1);
        wait_until(a2 + 113);
        applyStimulus(0, 1'b1, 1'b0);
        a3 = a2 + 113;
        wait_until(a3 + 1);
        applyStimulus(0, 1'b0, 1'b0);

        // Reset in the gap between stages 4 and 5.
        wait_until(a3 + 174);
        rst = 1'b0;
        flush_all();
        #1;
        checkValue("rst_busy", int'(bus_a.busy), 0);
        checkValue("rst_stage_idx", int'(bus_a.stage_idx), 0);
        checkValue("rst_cycle_idx", int'(bus_a.cycle_idx), 0);
        checkValue("rst_stage_start", int'(bus_a.stage_start), 0);
        checkValue("rst_job_done", int'(bus_a.job_done), 0);
        wait_until(a3 + 178);
        rst = 1'b1;

        // Random valid/abort traffic on both configurations.
        for (int n = 0; n < 1500; n++) begin
            wait_until(cyc + 1);
            for (int d = 0; d < 2; d++) begin
                applyStimulus(d, 1'($urandom % 2), 1'(($urandom % 48) == 0));
            end
        end
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        wait_until(cyc + 400);

        checkValue("queue_empty", exp_q.size(), 0);
        checkValue("done_latency_a", first_done[0] - base, 349);
        checkValue("done_latency_b", first_done[1] - base, 67);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
